// File: rtl/i2c_slave_fsm.sv
// I2C target controller: oversamples SCL/SDA on the system clock, detects
// START/STOP, matches a fixed 7-bit address and moves bytes to/from user logic.
// SDA is open-drain: sda_oe=1 pulls the line low.
//
// state       | meaning
// IDLE        | bus free, waiting for START
// ADDR        | shifting in address byte + R/W
// ADDR_ACK    | driving ACK for a matched address
// WR_DATA     | receiving a byte from the master
// WR_ACK      | driving ACK for a received byte
// RD_DATA     | sending a byte to the master
// RD_ACK      | sampling the master ACK/NACK
// WAIT_STOP   | not addressed / done; wait for START or STOP
module i2c_slave_fsm #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       scl_clk,
  input  logic       reset,
  input  logic       SCL,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [2:0] state,
  output logic [2:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WR_DATA   = 3'd3,
    S_WR_ACK    = 3'd4,
    S_RD_DATA   = 3'd5,
    S_RD_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_ack_phase;
  logic       r_sda_oe;
  logic       r_tx_req;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       r_busy;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  // Synchronize the bus lines; reset to 1 so an idle bus produces no edges.
  always_ff @(posedge scl_clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & ~r_sda_d & w_sda;

  // Protocol FSM; START/STOP override every state.
  always_ff @(posedge scl_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_tx_req    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_tx_req   <= 1'b0;
      r_rx_valid <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_cnt       <= 3'd0;
        r_shift     <= 8'h00;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b1;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_cnt       <= 3'd0;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_cnt == 3'd7) begin
                r_cnt <= 3'd0;
                r_rw  <= w_sda;
                // r_shift[6:0] holds address bits 7..1 before this final shift
                if (r_shift[6:0] == SLAVE_ADDR) begin
                  r_state     <= S_ADDR_ACK;
                  r_ack_phase <= 1'b0;
                end else begin
                  r_state <= S_WAIT_STOP;
                end
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_cnt       <= 3'd0;
                if (r_rw) begin
                  r_state  <= S_RD_DATA;
                  r_tx_req <= 1'b1;
                  r_shift  <= tx_data;
                  r_sda_oe <= ~tx_data[7];
                end else begin
                  r_state  <= S_WR_DATA;
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_cnt == 3'd7) begin
                r_cnt       <= 3'd0;
                r_rx_data   <= {r_shift[6:0], w_sda};
                r_rx_valid  <= 1'b1;
                r_state     <= S_WR_ACK;
                r_ack_phase <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_cnt       <= 3'd0;
                r_state     <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_cnt == 3'd7) begin
                r_cnt       <= 3'd0;
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_state     <= S_RD_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
                r_cnt    <= r_cnt + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state  <= S_WAIT_STOP;
                r_sda_oe <= 1'b0;
              end else begin
                r_ack_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_phase) begin
              r_ack_phase <= 1'b0;
              r_tx_req    <= 1'b1;
              r_shift     <= tx_data;
              r_sda_oe    <= ~tx_data[7];
              r_cnt       <= 3'd0;
              r_state     <= S_RD_DATA;
            end
          end
          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign tx_req   = r_tx_req;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign state    = r_state;
  assign cnt      = r_cnt;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: a bit-level I2C master model drives SCL/SDA at
// 16 system clocks per SCL period; expected values are hand-computed.
module tb_i2c_slave_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl;
  logic       m_sda;
  logic [7:0] tx_data;
  logic       sda_oe;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [2:0] state;
  logic [2:0] cnt;
  wire        sda_bus = m_sda & ~sda_oe;

  i2c_slave_fsm #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .scl_clk (clk),
    .reset   (reset),
    .SCL     (m_scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .state   (state),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int oe_cyc = 0;

  // Running pulse/drive totals; tests work with differences.
  always @(negedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (tx_req)   tx_cnt <= tx_cnt + 1;
    if (sda_oe)   oe_cyc <= oe_cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b, output logic s);
    m_sda = b;
    w(4);
    m_scl = 1'b1;
    w(4);
    s = sda_bus;
    w(4);
    m_scl = 1'b0;
    w(4);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    w(4);
    m_scl = 1'b1;
    w(4);
    m_sda = 1'b0;
    w(4);
    m_scl = 1'b0;
    w(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    w(4);
    m_scl = 1'b1;
    w(4);
    m_sda = 1'b1;
    w(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) write_bit(b[i], s);
    write_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      write_bit(1'b1, s);
      d[i] = s;
    end
    write_bit(ack ? 1'b0 : 1'b1, s);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_rx;
    logic [7:0] exp_rxd;
    logic [2:0] exp_st;
  } wvec_t;

  wvec_t tbl[5];

  initial begin
    logic       a, d;
    logic [7:0] rb;
    logic       s;
    int         rx0, tx0, oe0;

    tbl[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 3'd3};
    tbl[1] = '{8'hA0, 8'hC3, 1'b1, 1'b1, 1, 8'hC3, 3'd3};
    tbl[2] = '{8'hA2, 8'h3C, 1'b0, 1'b0, 0, 8'hC3, 3'd7};
    tbl[3] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1, 8'hFF, 3'd3};
    tbl[4] = '{8'h20, 8'h55, 1'b0, 1'b0, 0, 8'hFF, 3'd7};

    reset   = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    tx_data = 8'h00;
    w(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_oe", 32'(sda_oe), 32'd0);
    chk("rst_txreq", 32'(tx_req), 32'd0);
    chk("rst_rxvalid", 32'(rx_valid), 32'd0);
    chk("rst_rxdata", 32'(rx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    w(4);

    // Single-byte writes, matching and non-matching addresses
    for (int k = 0; k < 5; k++) begin
      rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cyc;
      i2c_start();
      chk("wr_busy_start", 32'(busy), 32'd1);
      send_byte(tbl[k].addr, a);
      send_byte(tbl[k].data, d);
      chk("wr_addr_ack", 32'(a), 32'(tbl[k].exp_aack));
      chk("wr_data_ack", 32'(d), 32'(tbl[k].exp_dack));
      chk("wr_rx_pulses", 32'(rx_cnt - rx0), 32'(tbl[k].exp_rx));
      chk("wr_rx_data", 32'(rx_data), 32'(tbl[k].exp_rxd));
      chk("wr_tx_pulses", 32'(tx_cnt - tx0), 32'd0);
      chk("wr_oe_used", 32'(oe_cyc > oe0), 32'(tbl[k].exp_aack));
      chk("wr_state_pre_stop", 32'(state), 32'(tbl[k].exp_st));
      i2c_stop();
      chk("wr_state_post_stop", 32'(state), 32'd0);
      chk("wr_busy_post_stop", 32'(busy), 32'd0);
    end

    // Read one byte, master NACK
    tx_data = 8'hA5;
    tx0 = tx_cnt;
    i2c_start();
    send_byte(8'hA1, a);
    chk("rd1_addr_ack", 32'(a), 32'd1);
    read_byte(1'b0, rb);
    chk("rd1_byte", 32'(rb), 32'hA5);
    chk("rd1_tx_pulses", 32'(tx_cnt - tx0), 32'd1);
    chk("rd1_wait_stop", 32'(state), 32'd7);
    chk("rd1_oe_released", 32'(sda_oe), 32'd0);
    i2c_stop();
    chk("rd1_idle", 32'(state), 32'd0);

    // Read two bytes, ACK then NACK
    tx_data = 8'h11;
    tx0 = tx_cnt;
    i2c_start();
    send_byte(8'hA1, a);
    chk("rd2_addr_ack", 32'(a), 32'd1);
    tx_data = 8'h22;
    read_byte(1'b1, rb);
    chk("rd2_byte0", 32'(rb), 32'h11);
    read_byte(1'b0, rb);
    chk("rd2_byte1", 32'(rb), 32'h22);
    chk("rd2_tx_pulses", 32'(tx_cnt - tx0), 32'd2);
    i2c_stop();
    chk("rd2_idle", 32'(state), 32'd0);

    // Repeated START after 4 bits of a write byte, then a read
    rx0 = rx_cnt; tx0 = tx_cnt;
    tx_data = 8'h5A;
    i2c_start();
    send_byte(8'hA0, a);
    chk("rs_addr_ack", 32'(a), 32'd1);
    write_bit(1'b1, s);
    write_bit(1'b0, s);
    write_bit(1'b1, s);
    write_bit(1'b1, s);
    chk("rs_mid_state", 32'(state), 32'd3);
    chk("rs_mid_cnt", 32'(cnt), 32'd4);
    i2c_start();
    chk("rs_state_addr", 32'(state), 32'd1);
    chk("rs_cnt_zero", 32'(cnt), 32'd0);
    chk("rs_oe", 32'(sda_oe), 32'd0);
    chk("rs_no_rx", 32'(rx_cnt - rx0), 32'd0);
    send_byte(8'hA1, a);
    chk("rs_rd_ack", 32'(a), 32'd1);
    read_byte(1'b0, rb);
    chk("rs_rd_byte", 32'(rb), 32'h5A);
    chk("rs_tx_pulses", 32'(tx_cnt - tx0), 32'd1);
    i2c_stop();

    // Async reset while the address ACK is being held
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'hA0 >> i) & 8'h01) != 8'h00, s);
    m_sda = 1'b1;
    w(4);
    m_scl = 1'b1;
    w(4);
    chk("ar_oe_before", 32'(sda_oe), 32'd1);
    chk("ar_state_before", 32'(state), 32'd2);
    reset = 1'b0;
    #1;
    chk("ar_oe", 32'(sda_oe), 32'd0);
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    w(4);
    reset = 1'b1;
    w(8);
    chk("ar_idle_after", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
